voice_sequencer: RTL



---
 rtl/voice_sequencer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/voice_sequencer.sv
// voice_sequencer: per-voice register file, time-multiplexed slot sweep
// driving the shared oscillator, and a collector that mixes the returned
// samples into one sample per sweep.
// Optional feature macro: VOICE_SEQ_SATURATE_EN
//    defined   -> mix_out is the sweep sum clamped to the sample range
//    undefined -> mix_out is the sweep sum arithmetically shifted (average)

package voice_sequencer_pkg;
   typedef enum logic [1:0] {
      SINE     = 2'd0,
      SQUARE   = 2'd1,
      SAW      = 2'd2,
      TRIANGLE = 2'd3
   } wave_shape;

   localparam int FIXED_POINT        = 8;
   localparam int ENVELOPE_RESET_BIT = 0;
endpackage

module voice_sequencer
   import voice_sequencer_pkg::*;
#(
   parameter int WIDTH       = 24,
   parameter int N_WAVEGENS  = 4,
   parameter int OSC_LATENCY = 1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  wr_en,
   input  logic [$clog2(N_WAVEGENS)-1:0]         wr_voice,
   input  logic                                  wr_enable,
   input  logic [31:0]                           wr_freq,
   input  logic [WIDTH-1:0]                      wr_amplitude,
   input  wave_shape                             wr_shape,
   input  logic                                  wr_note_on,
   output logic [$clog2(N_WAVEGENS+1)-1:0]       osc_index,
   output logic                                  osc_enable,
   output logic [31:0]                           osc_freq,
   output logic [WIDTH-1:0]                      osc_amplitude,
   output wave_shape                             osc_shape,
   output logic [7:0]                            osc_cmds,
   input  logic signed [WIDTH+FIXED_POINT-1:0]   osc_out,
   output logic signed [WIDTH+FIXED_POINT-1:0]   mix_out,
   output logic                                  mix_valid
);

   localparam int IDX_W    = $clog2(N_WAVEGENS + 1);
   localparam int VOICE_W  = $clog2(N_WAVEGENS);
   localparam int SAMPLE_W = WIDTH + FIXED_POINT;
   localparam int ACC_W    = SAMPLE_W + $clog2(N_WAVEGENS);
   localparam logic [IDX_W-1:0] IDLE      = IDX_W'(N_WAVEGENS);
   localparam logic [IDX_W-1:0] LAST_VOICE = IDX_W'(N_WAVEGENS - 1);

   logic [IDX_W-1:0]          s;
   logic                      load_voice;
   logic [VOICE_W-1:0]        voice_sel;
   logic                      wr_valid;

   logic                      reg_enable    [N_WAVEGENS];
   logic [31:0]               reg_freq      [N_WAVEGENS];
   logic [WIDTH-1:0]          reg_amplitude [N_WAVEGENS];
   wave_shape                 reg_shape     [N_WAVEGENS];
   logic [N_WAVEGENS-1:0]     pending;
   logic [N_WAVEGENS-1:0]     pending_next;
   logic [7:0]                cmd_next;

   logic [IDX_W-1:0]          dly [OSC_LATENCY];
   logic [IDX_W-1:0]          d;
   logic signed [ACC_W-1:0]   acc;
   logic signed [ACC_W-1:0]   osc_ext;
   logic signed [ACC_W-1:0]   sum;
   logic signed [SAMPLE_W-1:0] mix_next;

   assign load_voice = (s < IDLE);
   assign voice_sel  = s[VOICE_W-1:0];
   assign wr_valid   = (int'(wr_voice) < N_WAVEGENS);
   assign d          = dly[OSC_LATENCY-1];
   assign osc_ext    = {{(ACC_W-SAMPLE_W){osc_out[SAMPLE_W-1]}}, osc_out};
   assign sum        = acc + osc_ext;

   // Slot counter sweeps every voice and then the idle slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         s <= '0;
      end else if (s == IDLE) begin
         s <= '0;
      end else begin
         s <= s + 1'b1;
      end
   end

   // Register file writes; the pending flag is handled separately below.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_WAVEGENS; i++) begin
            reg_enable[i]    <= 1'b0;
            reg_freq[i]      <= '0;
            reg_amplitude[i] <= '0;
            reg_shape[i]     <= SINE;
         end
      end else if (wr_en && wr_valid) begin
         reg_enable[wr_voice]    <= wr_enable;
         reg_freq[wr_voice]      <= wr_freq;
         reg_amplitude[wr_voice] <= wr_amplitude;
         reg_shape[wr_voice]     <= wr_shape;
      end
   end

   // Pending envelope resets: loading a voice consumes its flag, but a
   // note-on landing on the same edge re-arms it so it is never lost.
   always_comb begin
      pending_next = pending;
      cmd_next     = '0;
      if (load_voice) begin
         cmd_next[ENVELOPE_RESET_BIT] = pending[voice_sel];
         pending_next[voice_sel]      = 1'b0;
      end
      if (wr_en && wr_valid && wr_note_on) begin
         pending_next[wr_voice] = 1'b1;
      end
   end

   // Pending flag register.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
      end else begin
         pending <= pending_next;
      end
   end

   // Oscillator-facing outputs load the current slot from the register file
   // as it stood before this edge; the idle slot presents all zeros.
   always_ff @(posedge clk) begin
      if (rst) begin
         osc_index     <= IDLE;
         osc_enable    <= 1'b0;
         osc_freq      <= '0;
         osc_amplitude <= '0;
         osc_shape     <= SINE;
         osc_cmds      <= '0;
      end else begin
         osc_index <= s;
         osc_cmds  <= cmd_next;
         if (load_voice) begin
            osc_enable    <= reg_enable[voice_sel];
            osc_freq      <= reg_freq[voice_sel];
            osc_amplitude <= reg_amplitude[voice_sel];
            osc_shape     <= reg_shape[voice_sel];
         end else begin
            osc_enable    <= 1'b0;
            osc_freq      <= '0;
            osc_amplitude <= '0;
            osc_shape     <= SINE;
         end
      end
   end

   // Delay line tags each returning sample with the slot it belongs to;
   // stage 0 tracks osc_index itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < OSC_LATENCY; i++) begin
            dly[i] <= IDLE;
         end
      end else begin
         dly[0] <= s;
         for (int i = 1; i < OSC_LATENCY; i++) begin
            dly[i] <= dly[i-1];
         end
      end
   end

`ifdef VOICE_SEQ_SATURATE_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

   // Clamp the finished sweep sum to the representable sample range.
   always_comb begin
      mix_next = SAMPLE_W'(sum);
      if (sum > SAT_MAX) begin
         mix_next = SAMPLE_W'(SAT_MAX);
      end else if (sum < SAT_MIN) begin
         mix_next = SAMPLE_W'(SAT_MIN);
      end
   end
`else
   localparam int SHIFT = $clog2(N_WAVEGENS);

   // Average the finished sweep sum; this can never overflow the sample range.
   always_comb begin
      mix_next = SAMPLE_W'(sum >>> SHIFT);
   end
`endif

   // Collector: accumulate voice samples and emit one mix per sweep when the
   // last voice's sample arrives, restarting the accumulator on that edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         mix_out   <= '0;
         mix_valid <= 1'b0;
      end else begin
         mix_valid <= 1'b0;
         if (d == LAST_VOICE) begin
            mix_out   <= mix_next;
            mix_valid <= 1'b1;
            acc       <= '0;
         end else if (d < IDLE) begin
            acc <= sum;
         end
      end
   end

endmodule
